// File: rtl/apb_gpio_ctrl.sv
// APB3 GPIO controller: per-pin direction, atomic set/clear/toggle of outputs,
// two-flop input synchroniser with optional debounce filter, and per-pin
// level/edge interrupts with write-1-to-clear status.
module apb_gpio_ctrl #(
  parameter int          IO_NUM          = 8,
  parameter int          DEBOUNCE_CYCLES = 0,
  parameter logic [31:0] OUT_RESET       = 32'h0,
  parameter logic [31:0] OE_RESET        = 32'h0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [IO_NUM-1:0] GPIO_IN,
  output logic [IO_NUM-1:0] GPIO_OUT,
  output logic [IO_NUM-1:0] GPIO_OE,
  output logic [IO_NUM-1:0] INT,
  output logic              INT_OR
);

  // Word offsets (PADDR[7:2]) of the register map.
  localparam logic [5:0] W_OUT      = 6'd0;
  localparam logic [5:0] W_OUT_SET  = 6'd1;
  localparam logic [5:0] W_OUT_CLR  = 6'd2;
  localparam logic [5:0] W_OUT_TGL  = 6'd3;
  localparam logic [5:0] W_OE       = 6'd4;
  localparam logic [5:0] W_IN       = 6'd5;
  localparam logic [5:0] W_INT_EN   = 6'd6;
  localparam logic [5:0] W_INT_EDGE = 6'd7;
  localparam logic [5:0] W_INT_POL  = 6'd8;
  localparam logic [5:0] W_INT_BOTH = 6'd9;
  localparam logic [5:0] W_INT_STAT = 6'd10;

  logic [5:0]        word;
  logic              mapped;
  logic              wr_en;
  logic [IO_NUM-1:0] wdata;
  logic [IO_NUM-1:0] rdata;
  logic              unused_bits;

  logic [IO_NUM-1:0] out_q, out_d;
  logic [IO_NUM-1:0] oe_q, oe_d;
  logic [IO_NUM-1:0] en_q, en_d;
  logic [IO_NUM-1:0] edge_q, edge_d;
  logic [IO_NUM-1:0] pol_q, pol_d;
  logic [IO_NUM-1:0] both_q, both_d;
  logic [IO_NUM-1:0] stat_q, stat_d;
  logic [IO_NUM-1:0] s1_q, s2_q, fdly_q;
  logic [IO_NUM-1:0] filt;
  logic [IO_NUM-1:0] evt;
  logic [IO_NUM-1:0] w1c;

  assign word        = PADDR[7:2];
  assign mapped      = (word <= W_INT_STAT);
  assign wr_en       = PSEL & PENABLE & PWRITE & mapped;
  assign wdata       = PWDATA[IO_NUM-1:0];
  // Byte-lane bits and write data above the pin count carry no meaning here.
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  assign PREADY   = 1'b1;
  assign PSLVERR  = PSEL & PENABLE & ~mapped;
  assign GPIO_OUT = out_q;
  assign GPIO_OE  = oe_q;
  assign INT      = stat_q & en_q;
  assign INT_OR   = |INT;

  // Read mux: purely combinational, no side effects; idle bus reads 0.
  always_comb begin
    rdata = '0;
    case (word)
      W_OUT:      rdata = out_q;
      W_OE:       rdata = oe_q;
      W_IN:       rdata = filt;
      W_INT_EN:   rdata = en_q;
      W_INT_EDGE: rdata = edge_q;
      W_INT_POL:  rdata = pol_q;
      W_INT_BOTH: rdata = both_q;
      W_INT_STAT: rdata = stat_q;
      default:    rdata = '0;
    endcase
  end

  assign PRDATA = PSEL ? 32'(rdata) : 32'h0;

  // Next state of the software-writable control registers.
  always_comb begin
    out_d  = out_q;
    oe_d   = oe_q;
    en_d   = en_q;
    edge_d = edge_q;
    pol_d  = pol_q;
    both_d = both_q;
    if (wr_en) begin
      case (word)
        W_OUT:      out_d  = wdata;
        W_OUT_SET:  out_d  = out_q | wdata;
        W_OUT_CLR:  out_d  = out_q & ~wdata;
        W_OUT_TGL:  out_d  = out_q ^ wdata;
        W_OE:       oe_d   = wdata;
        W_INT_EN:   en_d   = wdata;
        W_INT_EDGE: edge_d = wdata;
        W_INT_POL:  pol_d  = wdata;
        W_INT_BOTH: both_d = wdata;
        default:    ;
      endcase
    end
  end

  // Interrupt events and status: an event always wins over a same-cycle W1C,
  // so a persisting level keeps its status bit set.
  always_comb begin
    evt = (edge_q & both_q & (filt ^ fdly_q))
        | (edge_q & ~both_q & pol_q & filt & ~fdly_q)
        | (edge_q & ~both_q & ~pol_q & ~filt & fdly_q)
        | (~edge_q & ~(filt ^ pol_q));
    w1c    = (wr_en && word == W_INT_STAT) ? wdata : '0;
    stat_d = (stat_q & ~w1c) | evt;
  end

  // Register bank, synchroniser and delayed filtered input.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      out_q  <= OUT_RESET[IO_NUM-1:0];
      oe_q   <= OE_RESET[IO_NUM-1:0];
      en_q   <= '0;
      edge_q <= '0;
      pol_q  <= '0;
      both_q <= '0;
      stat_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      fdly_q <= '0;
    end else begin
      out_q  <= out_d;
      oe_q   <= oe_d;
      en_q   <= en_d;
      edge_q <= edge_d;
      pol_q  <= pol_d;
      both_q <= both_d;
      stat_q <= stat_d;
      s1_q   <= GPIO_IN;
      s2_q   <= s1_q;
      fdly_q <= filt;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt = s2_q;
    end else begin : g_debounce
      localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
      for (genvar gi = 0; gi < IO_NUM; gi++) begin : g_pin
        logic        filt_q, filt_d;
        logic [15:0] cnt_q, cnt_d;

        // Filtered value only follows s2 after it differs for CNT_LAST+1 edges.
        always_comb begin
          filt_d = filt_q;
          cnt_d  = cnt_q;
          if (s2_q[gi] == filt_q) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            filt_d = s2_q[gi];
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        // Debounce state; reset discards any partial count.
        always_ff @(posedge PCLK) begin
          if (PRESET) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
          end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
          end
        end

        assign filt[gi] = filt_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Bench for apb_gpio_ctrl: two instances (A: no debounce, OUT/OE reset values
// set; B: 4-cycle debounce). Stimulus pushes expected results into a queue;
// a monitor pops and compares on every APB access phase.
module tb_apb_gpio_ctrl;

  localparam logic [7:0] A_OUT  = 8'h00, A_SET  = 8'h04, A_CLR  = 8'h08, A_TGL  = 8'h0C;
  localparam logic [7:0] A_OE   = 8'h10, A_IN   = 8'h14, A_EN   = 8'h18, A_EDGE = 8'h1C;
  localparam logic [7:0] A_POL  = 8'h20, A_BOTH = 8'h24, A_STAT = 8'h28, A_BAD  = 8'h40;

  // check mask bits
  localparam bit [4:0] C_RD = 5'b00001, C_ERR = 5'b00010, C_OUT = 5'b00100;
  localparam bit [4:0] C_OE = 5'b01000, C_INT = 5'b10000;

  logic        clk = 1'b0;
  logic        preset_a = 1'b1, preset_b = 1'b1;
  logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [7:0]  gpio_a = '0, gpio_b = '0;

  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b, intor_a, intor_b;
  logic [7:0]  out_a, out_b, oe_a, oe_b, int_a, int_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    bit          is_b;
    bit [4:0]    chk;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  out;
    logic [7:0]  oe;
    logic        intor;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  apb_gpio_ctrl #(.IO_NUM(8), .DEBOUNCE_CYCLES(0), .OUT_RESET(32'hA5), .OE_RESET(32'h0F)) dut_a (
    .PCLK(clk), .PRESET(preset_a), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a),
    .GPIO_IN(gpio_a), .GPIO_OUT(out_a), .GPIO_OE(oe_a), .INT(int_a), .INT_OR(intor_a)
  );

  apb_gpio_ctrl #(.IO_NUM(8), .DEBOUNCE_CYCLES(4), .OUT_RESET(32'h0), .OE_RESET(32'h0)) dut_b (
    .PCLK(clk), .PRESET(preset_b), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b),
    .GPIO_IN(gpio_b), .GPIO_OUT(out_b), .GPIO_OE(oe_b), .INT(int_b), .INT_OR(intor_b)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Monitor: one popped expectation per access phase, sampled mid-cycle.
  always @(negedge clk) begin
    if ((psel_a || psel_b) && penable) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_txn: got access addr %h expected none", paddr);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_b) begin
          if (mon_e.chk[0]) check({mon_e.tag, ".prdata"}, prdata_b, mon_e.rdata);
          if (mon_e.chk[1]) check({mon_e.tag, ".pslverr"}, 32'(pslverr_b), 32'(mon_e.err));
          if (mon_e.chk[2]) check({mon_e.tag, ".gpio_out"}, 32'(out_b), 32'(mon_e.out));
          if (mon_e.chk[3]) check({mon_e.tag, ".gpio_oe"}, 32'(oe_b), 32'(mon_e.oe));
          if (mon_e.chk[4]) check({mon_e.tag, ".int_or"}, 32'(intor_b), 32'(mon_e.intor));
        end else begin
          if (mon_e.chk[0]) check({mon_e.tag, ".prdata"}, prdata_a, mon_e.rdata);
          if (mon_e.chk[1]) check({mon_e.tag, ".pslverr"}, 32'(pslverr_a), 32'(mon_e.err));
          if (mon_e.chk[2]) check({mon_e.tag, ".gpio_out"}, 32'(out_a), 32'(mon_e.out));
          if (mon_e.chk[3]) check({mon_e.tag, ".gpio_oe"}, 32'(oe_a), 32'(mon_e.oe));
          if (mon_e.chk[4]) check({mon_e.tag, ".int_or"}, 32'(intor_a), 32'(mon_e.intor));
        end
        $display("txn %s dut=%s %s addr=%h", mon_e.tag, mon_e.is_b ? "B" : "A",
                 pwrite ? "wr" : "rd", paddr);
      end
    end
  end

  task automatic push(input string tag, input bit b, input bit [4:0] chk, input logic [31:0] rdata,
                      input logic err, input logic [7:0] out, input logic [7:0] oe, input logic intor);
    exp_t e;
    e.tag = tag; e.is_b = b; e.chk = chk; e.rdata = rdata;
    e.err = err; e.out = out; e.oe = oe; e.intor = intor;
    exp_q.push_back(e);
  endtask

  task automatic apb(input bit b, input bit wr, input logic [7:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    psel_a = !b; psel_b = b; pwrite = wr; paddr = addr; pwdata = data; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input bit b, input logic [7:0] addr, input logic [31:0] data, input string tag);
    push(tag, b, C_ERR, '0, 1'b0, '0, '0, 1'b0);
    apb(b, 1'b1, addr, data);
  endtask

  task automatic rd(input bit b, input logic [7:0] addr, input logic [31:0] exp, input string tag);
    push(tag, b, C_RD | C_ERR, exp, 1'b0, '0, '0, 1'b0);
    apb(b, 1'b0, addr, 32'h0);
  endtask

  task automatic rd_int(input logic [7:0] addr, input logic [31:0] exp, input logic intor, input string tag);
    push(tag, 1'b0, C_RD | C_ERR | C_INT, exp, 1'b0, '0, '0, intor);
    apb(1'b0, 1'b0, addr, 32'h0);
  endtask

  task automatic rd_pins(input logic [7:0] addr, input logic [31:0] exp, input logic [7:0] out,
                         input logic [7:0] oe, input string tag);
    push(tag, 1'b0, C_RD | C_ERR | C_OUT | C_OE, exp, 1'b0, out, oe, 1'b0);
    apb(1'b0, 1'b0, addr, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish within 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset values, read while reset is held ----
    push("rst_out", 1'b0, C_RD | C_ERR | C_OUT | C_OE | C_INT, 32'hA5, 1'b0, 8'hA5, 8'h0F, 1'b0);
    apb(1'b0, 1'b0, A_OUT, 32'h0);
    rd_pins(A_OE, 32'h0F, 8'hA5, 8'h0F, "rst_oe");
    rd(1'b0, A_IN, 32'h0, "rst_in");
    rd(1'b0, A_EN, 32'h0, "rst_en");
    rd(1'b0, A_EDGE, 32'h0, "rst_edge");
    rd(1'b0, A_POL, 32'h0, "rst_pol");
    rd(1'b0, A_BOTH, 32'h0, "rst_both");
    rd_int(A_STAT, 32'h0, 1'b0, "rst_stat");
    preset_a = 1'b0;
    preset_b = 1'b0;

    // ---- output register and atomic set/clear/toggle ----
    rd_pins(A_OUT, 32'hA5, 8'hA5, 8'h0F, "out_after_rst");
    wr(1'b0, A_OUT, 32'h0, "wr_out0");
    wr(1'b0, A_SET, 32'h81, "wr_set");
    rd_pins(A_OUT, 32'h81, 8'h81, 8'h0F, "out_set");
    wr(1'b0, A_CLR, 32'h01, "wr_clr");
    rd_pins(A_OUT, 32'h80, 8'h80, 8'h0F, "out_clr");
    wr(1'b0, A_TGL, 32'hFF, "wr_tgl");
    rd_pins(A_OUT, 32'h7F, 8'h7F, 8'h0F, "out_tgl");
    rd(1'b0, A_SET, 32'h0, "rd_set0");
    rd(1'b0, A_CLR, 32'h0, "rd_clr0");
    rd(1'b0, A_TGL, 32'h0, "rd_tgl0");

    // ---- edge interrupt, rising on pin 3 (default level-low mode sets
    //      status after reset, so switch to edge mode and clear first) ----
    wr(1'b0, A_EDGE, 32'hFF, "wr_edge");
    wr(1'b0, A_STAT, 32'hFF, "w1c_all");
    rd(1'b0, A_STAT, 32'h0, "stat_clear");
    wr(1'b0, A_POL, 32'h08, "wr_pol3");
    gpio_a[3] = 1'b1;                           // stable before edge k
    rd(1'b0, A_STAT, 32'h0, "stat_k1");         // sampled after edge k+1
    rd(1'b0, A_IN, 32'h08, "in_pin3");
    rd_int(A_STAT, 32'h08, 1'b0, "stat_rise_noen");
    wr(1'b0, A_EN, 32'h08, "wr_en3");
    rd_int(A_STAT, 32'h08, 1'b1, "stat_rise_en");
    wr(1'b0, A_STAT, 32'h08, "w1c3");
    rd_int(A_STAT, 32'h0, 1'b0, "stat_w1c3");
    wr(1'b0, A_BOTH, 32'h08, "wr_both3");
    gpio_a[3] = 1'b0;                           // falling event lands on the W1C commit edge
    wr(1'b0, A_STAT, 32'h08, "w1c3_coincident");
    rd_int(A_STAT, 32'h08, 1'b1, "stat_event_wins");

    // ---- level-high interrupt on pin 0 ----
    wr(1'b0, A_POL, 32'h09, "wr_pol09");
    gpio_a[0] = 1'b1;
    wr(1'b0, A_EDGE, 32'hFE, "wr_edge_lvl0");
    wr(1'b0, A_STAT, 32'h09, "w1c09");
    rd_int(A_STAT, 32'h01, 1'b0, "stat_level_sticks");
    gpio_a[0] = 1'b0;
    rd(1'b0, A_STAT, 32'h01, "stat_level_held");
    wr(1'b0, A_STAT, 32'h01, "w1c0");
    rd(1'b0, A_STAT, 32'h0, "stat_level_cleared");

    // ---- unmapped address ----
    push("wr_unmapped", 1'b0, C_ERR, '0, 1'b1, '0, '0, 1'b0);
    apb(1'b0, 1'b1, A_BAD, 32'hFFFF_FFFF);
    push("rd_unmapped", 1'b0, C_RD | C_ERR, 32'h0, 1'b1, '0, '0, 1'b0);
    apb(1'b0, 1'b0, A_BAD, 32'h0);
    rd_pins(A_OUT, 32'h7F, 8'h7F, 8'h0F, "out_unchanged");
    rd(1'b0, A_EN, 32'h08, "en_unchanged");

    // ---- bits above IO_NUM read 0 ----
    wr(1'b0, A_OE, 32'hFFFF_FFFF, "wr_oe_all");
    rd_pins(A_OE, 32'hFF, 8'h7F, 8'hFF, "oe_masked");

    // ---- debounce instance (D = 4) ----
    wr(1'b1, A_EDGE, 32'hFF, "b_wr_edge");
    wr(1'b1, A_STAT, 32'hFF, "b_w1c_all");
    rd(1'b1, A_STAT, 32'h0, "b_stat_clear");
    fork                                        // 3-cycle glitch
      begin gpio_b[5] = 1'b1; repeat (3) @(posedge clk); #1 gpio_b[5] = 1'b0; end
      begin repeat (3) @(posedge clk); #1; rd(1'b1, A_IN, 32'h0, "b_glitch_in"); end
    join
    repeat (10) @(posedge clk);
    #1;
    rd(1'b1, A_IN, 32'h0, "b_glitch_in_late");
    rd(1'b1, A_STAT, 32'h0, "b_glitch_stat");
    fork                                        // 6-cycle pulse, sample after edge k+4
      begin gpio_b[5] = 1'b1; repeat (6) @(posedge clk); #1 gpio_b[5] = 1'b0; end
      begin repeat (3) @(posedge clk); #1; rd(1'b1, A_IN, 32'h0, "b_pulse_k4"); end
    join
    repeat (20) @(posedge clk);
    #1;
    fork                                        // 6-cycle pulse, sample after edge k+5
      begin gpio_b[5] = 1'b1; repeat (6) @(posedge clk); #1 gpio_b[5] = 1'b0; end
      begin repeat (4) @(posedge clk); #1; rd(1'b1, A_IN, 32'h20, "b_pulse_k5"); end
    join
    repeat (20) @(posedge clk);
    #1;
    rd(1'b1, A_IN, 32'h0, "b_pulse_gone");

    // ---- reset mid-debounce: partial count discarded ----
    gpio_b[5] = 1'b1;
    repeat (3) @(posedge clk);
    #1 preset_b = 1'b1;
    @(posedge clk);
    #1 preset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd(1'b1, A_IN, 32'h0, "b_rst_count_cleared");
    rd(1'b1, A_IN, 32'h20, "b_rst_then_settled");

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_gpio_ctrl.md
# apb_gpio_ctrl

Parametrised APB3 general-purpose I/O controller, 1–32 pins, for the MI-V peripheral subsystem on the APB bus behind the AHB-to-APB bridge. Adds the following over the fixed-configuration GPIO:
- runtime per-pin direction
- atomic set/clear/toggle of outputs
- 2-flop input synchronisation with an optional debounce filter
- per-pin programmable interrupt mode with write-1-to-clear status

## Interface
Parameters:
- IO_NUM, 8, pin count, 1..32; register bits above IO_NUM-1 read 0 and ignore writes
- DEBOUNCE_CYCLES, 0, stable cycles required before the filtered input changes, 0..65535; 0 = bypass
- OUT_RESET, 32'h0, GPIO_OUT reset value
- OE_RESET, 32'h0, GPIO_OE reset value

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write
- PADDR  in  8  byte address; [1:0] ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data, combinational from PADDR
- PREADY  out  1  tied 1 (zero wait states)
- PSLVERR  out  1  high during access phase to an unmapped address
- GPIO_IN  in  IO_NUM  asynchronous pin inputs
- GPIO_OUT  out  IO_NUM  output data register
- GPIO_OE  out  IO_NUM  output enable, 1 = drive
- INT  out  IO_NUM  per-pin interrupt, INT_STAT & INT_EN
- INT_OR  out  1  OR of INT

## Operation
A write commits on the PCLK edge where PSEL & PENABLE & PWRITE are all high. Register map (offset, access, reset):
- 0x00 OUT, RW, OUT_RESET
- 0x04 OUT_SET, WO: OUT |= PWDATA; reads 0
- 0x08 OUT_CLR, WO: OUT &= ~PWDATA; reads 0
- 0x0C OUT_TGL, WO: OUT ^= PWDATA; reads 0
- 0x10 OE, RW, OE_RESET
- 0x14 IN, RO: filtered input f
- 0x18 INT_EN, RW, 0
- 0x1C INT_EDGE, RW, 0: 1 = edge mode, 0 = level mode
- 0x20 INT_POL, RW, 0: level mode 1 = high / 0 = low; edge mode 1 = rising / 0 = falling
- 0x24 INT_BOTH, RW, 0: in edge mode, 1 = both edges (overrides POL)
- 0x28 INT_STAT, RW1C, 0

Addresses ≥0x2C:
- read 0 and are not written
- PSLVERR = 1 when PSEL & PENABLE are high

Input path, per pin:
- s1 <= GPIO_IN; s2 <= s1
- DEBOUNCE_CYCLES = 0: f = s2
- Otherwise, per-pin counter cnt:
  - s2 == f: cnt <= 0
  - s2 != f and cnt == DEBOUNCE_CYCLES-1: f <= s2, cnt <= 0
  - s2 != f otherwise: cnt++
- Any glitch shorter than DEBOUNCE_CYCLES never reaches f.
- f_d <= f every cycle.

Interrupt event (combinational), per pin:
- Level mode: f == POL
- Edge mode: BOTH ? (f ^ f_d) : POL ? (f & ~f_d) : (~f & f_d)

INT_STAT[i] next-state:
- Event: set to 1
- Otherwise, W1C write with PWDATA[i] = 1: clear to 0
- Otherwise: hold

Further rules:
- An event and a W1C in the same cycle: the event wins (stays 1).
- Level mode: a W1C while the level persists re-sets the bit on the same edge, so the bit never clears.
- Status records events regardless of INT_EN. INT_EN gates INT/INT_OR only.

## Timing
- Reset (PRESET high at an edge):
  - GPIO_OUT = OUT_RESET, GPIO_OE = OE_RESET
  - all other registers, s1/s2/f/f_d, cnt = 0
  - INT = 0, INT_OR = 0, PSLVERR = 0
  - PRDATA = 0 when PSEL = 0; PREADY = 1
- Reset asserted mid-debounce discards the count. A pin held high through reset produces an edge-mode rising event 2 cycles (+ DEBOUNCE_CYCLES) after release. Software clears INT_STAT before setting INT_EN.
- Write to GPIO_OUT/GPIO_OE/INT_EN: visible the cycle after the commit edge.
- Pin change stable before edge k:
  - s2 updates at edge k+1; IN readable after edge k+1 (D = 0), or after edge k+1+D (D > 0)
  - f changes at edge k+1 (D = 0) or k+1+D (D > 0); INT_STAT sets on the next edge; INT/INT_OR follow combinationally
- Read: PRDATA valid throughout setup and access phases; no read side effects.

## Test plan
- Reset, OUT_RESET = 0xA5, OE_RESET = 0x0F, IO_NUM = 8 -> GPIO_OUT = 0xA5, GPIO_OE = 0x0F, reads of 0x18–0x28 return 0, INT_OR = 0.
- OUT = 0x00, then SET 0x81, then CLR 0x01, then TGL 0xFF -> GPIO_OUT 0x81, 0x80, 0x7F; reads of 0x04/0x08/0x0C return 0.
- Edge, rising, pin 3, D = 0: GPIO_IN[3] rises before edge k -> INT_STAT = 0x08 at edge k+2. With INT_EN = 0x08, INT_OR = 1. W1C 0x08 -> 0 next cycle; a W1C coincident with a new edge leaves the bit at 1.
- Level high on pin 0 held high -> W1C leaves INT_STAT[0] = 1. Drop the pin -> the W1C clears it.
- D = 4: 3-cycle glitch on pin 5 -> IN unchanged, no status. 6-cycle pulse -> IN[5] = 1 after edge k+5.
- Write/read to 0x40 -> PSLVERR = 1 during the access phase, PRDATA = 0, no register changes. PRESET asserted mid-debounce -> cnt and f return to 0.
